// File: rtl/if_id_stage_if.sv
// Instruction-memory fetch handshake between the IF stage (master) and imem (slave).
interface if_id_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_id_stage.sv
// MIPS fetch front-end and IF/ID register: PC, imem handshake, load-use stall, redirect squash.
// Define IF_DELAY_SLOT_EN to keep the branch delay-slot word instead of squashing it on redirect.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic          clk,
    input  logic          reset,
    if_id_stage_if.master imem,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    input  logic          idex_MemRead,
    input  logic [4:0]    idex_rt,
    output logic [5:0]    OpCode,
    output logic [5:0]    Funct,
    output logic [4:0]    Rs,
    output logic [4:0]    Rt,
    output logic [4:0]    Rd,
    output logic [4:0]    Shamt,
    output logic [15:0]   Imm,
    output logic [31:0]   PC_id,
    output logic          nop,
    output logic          stall
);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [31:0] skid;
    logic        valid;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];
    assign pc_plus4       = pc + 32'd4;

    assign OpCode = instr[31:26];
    assign Rs     = instr[25:21];
    assign Rt     = instr[20:16];
    assign Rd     = instr[15:11];
    assign Shamt  = instr[10:6];
    assign Funct  = instr[5:0];
    assign Imm    = instr[15:0];

    assign stall = idex_MemRead & valid & (idex_rt != 5'd0) &
                   ((idex_rt == Rs) | (idex_rt == Rt));
    assign nop   = ~valid | stall;

    // Request is suppressed while reset is held and while the skid buffer owns the word.
    assign imem.imem_req  = reset & (state == S_FETCH);
    assign imem.imem_addr = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            instr <= '0;
            PC_id <= '0;
            valid <= 1'b0;
            skid  <= '0;
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[31:2], 2'b00};
            state <= S_FETCH;
`ifdef IF_DELAY_SLOT_EN
            if (state == S_HOLD) begin
                instr <= skid;
                PC_id <= pc_plus4;
                valid <= 1'b1;
            end else if (imem.imem_ready) begin
                instr <= imem.imem_rdata;
                PC_id <= pc_plus4;
                valid <= 1'b1;
            end else begin
                valid <= 1'b0;
            end
`else
            valid <= 1'b0;
`endif
        end else if (state == S_HOLD) begin
            if (!stall) begin
                instr <= skid;
                PC_id <= pc_plus4;
                valid <= 1'b1;
                pc    <= pc_plus4;
                state <= S_FETCH;
            end
        end else if (imem.imem_ready) begin
            if (stall) begin
                // Word already returned for pc; park it so the fetch is not repeated.
                skid  <= imem.imem_rdata;
                state <= S_HOLD;
            end else begin
                instr <= imem.imem_rdata;
                PC_id <= pc_plus4;
                valid <= 1'b1;
                pc    <= pc_plus4;
            end
        end else if (!stall) begin
            valid <= 1'b0;
        end
    end

endmodule
